car_light_seq: RTL and testbench
================================

CAR_LIGHT_SEQ -- requirements
Module: car_light_seq

Interface
REQ-001 The block SHALL have parameter N_LED, default 8, giving the number of status LEDs (minimum 2).
REQ-002 The block SHALL have parameter SEG_LEN, default 4, giving the lit segment length for chase modes (1 to N_LED-1).
REQ-003 The block SHALL have parameter STEP_DIV, default 6000000, giving clk cycles per step.
REQ-004 The block SHALL have parameter BLINK_STEPS, default 2, giving steps per RGB blink half-period.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en_l, input, 1 bit: left turn request.
REQ-008 The block SHALL have port en_r, input, 1 bit: right turn request.
REQ-009 The block SHALL have port hazard, input, 1 bit: hazard request.
REQ-010 The block SHALL have port brake, input, 1 bit: brake request.
REQ-011 The block SHALL have port rgb_led_1_n, output, 3 bits: left lamp {R,G,B}, active-low.
REQ-012 The block SHALL have port rgb_led_2_n, output, 3 bits: right lamp {R,G,B}, active-low.
REQ-013 The block SHALL have port status_led_n, output, N_LED bits: status bar, active-low, bit 0 = rightmost.

Function
REQ-014 Each of en_l, en_r, hazard and brake SHALL pass through a 2-flop synchroniser, and all outputs SHALL be registered; an input change SHALL reach the outputs 3 clk later.
REQ-015 The FSM SHALL have states IDLE, LEFT, RIGHT and HAZARD, selected by priority: (hazard or (en_l and en_r)) selects HAZARD, else en_l selects LEFT, else en_r selects RIGHT, else IDLE.
REQ-016 The step counter SHALL count 0 to STEP_DIV-1 and emit a 1-cycle step pulse at wrap.
REQ-017 Any state change SHALL clear the step counter and the blink counter, so the first step occurs STEP_DIV cycles after entry.
REQ-018 The blink phase SHALL start at 1 (on) on entry to a state and SHALL toggle every BLINK_STEPS steps.
REQ-019 On entry to LEFT, the status pattern SHALL light bits [SEG_LEN-1:0], and each step SHALL rotate the pattern left by 1 with wrap from the MSB to bit 0.
REQ-020 On entry to RIGHT, the status pattern SHALL light bits [N_LED-1:N_LED-SEG_LEN], and each step SHALL rotate the pattern right by 1 with wrap from bit 0 to the MSB.
REQ-021 In HAZARD, all status LEDs SHALL be lit on entry and SHALL toggle all-on/all-off each step.
REQ-022 In IDLE, all status LEDs SHALL be off (all 1s), except that when brake is asserted all status LEDs SHALL be lit steadily.
REQ-023 rgb_led_1_n SHALL be 3'b000 when in LEFT or HAZARD with blink phase on; otherwise it SHALL be 3'b011 if brake is asserted, else 3'b111.
REQ-024 rgb_led_2_n SHALL follow the same rule as rgb_led_1_n, for RIGHT or HAZARD.
REQ-025 A direct LEFT-to-RIGHT change (or the reverse) SHALL reload the entry pattern of the new state, not continue the old rotation.
REQ-026 brake SHALL NOT alter the FSM state, the step counter or the blink counter.

Reset
REQ-027 While rst is high at a clk edge, the block SHALL force state IDLE, clear all counters and synchroniser flops, and drive status_led_n all 1s and both RGB outputs to 3'b111.
REQ-028 Asserting rst mid-pattern SHALL take effect at the next clk edge, and after rst is released the block SHALL restart from IDLE as in REQ-014.

Structure
REQ-029 Package car_light_pkg SHALL hold the state enum (IDLE, LEFT, RIGHT, HAZARD) and the RGB constants RGB_OFF, RGB_WHITE and RGB_RED.
REQ-030 The step counter with its restart input SHALL be the single sub-module step_tick, parameterised by STEP_DIV.

Verification (N_LED=8, SEG_LEN=4, STEP_DIV=4, BLINK_STEPS=2)
REQ-031 The bench SHALL check: reset then idle inputs -> status_led_n=8'hFF and both RGB outputs 3'b111 indefinitely.
REQ-032 The bench SHALL check: en_l=1 -> 3 clk later status_led_n=8'hF0, then 8'hE1 and 8'hC3 at successive 4-clk steps, with rgb_led_1_n at 3'b000 for 8 clk then 3'b111 for 8 clk.
REQ-033 The bench SHALL check: en_r=1 -> status_led_n=8'h0F, then 8'h87; switching to en_l mid-run -> 8'hF0 reloaded 3 clk after the change.
REQ-034 The bench SHALL check: en_l=en_r=1, or hazard=1 -> status_led_n alternates 8'h00/8'hFF every 4 clk, and both RGB outputs blink in phase.
REQ-035 The bench SHALL check: brake=1 in IDLE -> status_led_n=8'h00 and both RGB outputs 3'b011; brake=1 in LEFT -> rgb_led_2_n=3'b011 with the left chase unchanged.
REQ-036 The bench SHALL check: rst pulsed during a LEFT rotation -> all outputs off on the next clk, and the chase resumes from 8'hF0 once rst is released.

Source files
------------

// File: rtl/car_light_pkg.sv
// Shared types and constants for the car light sequencer.
// Lamp encodings are active-low {R,G,B}.
package car_light_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZARD
  } state_t;

  typedef struct packed {
    logic l;
    logic r;
    logic hz;
    logic brk;
  } req_t;

  localparam logic [2:0] RGB_OFF   = 3'b111;
  localparam logic [2:0] RGB_WHITE = 3'b000;
  localparam logic [2:0] RGB_RED   = 3'b011;

  function automatic state_t pick_state(
    input req_t rq
  );
    if (rq.hz || (rq.l && rq.r))
      return HAZARD;
    else if (rq.l)
      return LEFT;
    else if (rq.r)
      return RIGHT;
    else
      return IDLE;
  endfunction

endpackage

// File: rtl/car_light_seq_step_tick.sv
// Free-running step divider with restart.
// tick is high for the last count of each period.
module step_tick
  #(parameter int STEP_DIV = 6000000)
  (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
  );

  localparam int CW =
    (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  // count 0..STEP_DIV-1, cleared on restart
  always_ff @(posedge clk) begin
    if (rst || restart)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/car_light_seq.sv
// Turn/hazard/brake light sequencer.
// Inputs synchronised, all outputs registered.
module car_light_seq
  import car_light_pkg::*;
  #(
    parameter int N_LED       = 8,
    parameter int SEG_LEN     = 4,
    parameter int STEP_DIV    = 6000000,
    parameter int BLINK_STEPS = 2
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_l,
    input  logic             en_r,
    input  logic             hazard,
    input  logic             brake,
    output logic [2:0]       rgb_led_1_n,
    output logic [2:0]       rgb_led_2_n,
    output logic [N_LED-1:0] status_led_n
  );

  localparam int BW =
    (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'(BLINK_STEPS - 1);

  localparam logic [N_LED-1:0] L_INIT =
    {{(N_LED-SEG_LEN){1'b0}}, {SEG_LEN{1'b1}}};
  localparam logic [N_LED-1:0] R_INIT =
    {{SEG_LEN{1'b1}}, {(N_LED-SEG_LEN){1'b0}}};

  req_t raw;
  req_t s1;
  req_t s2;

  state_t state;
  state_t state_n;
  state_t target;

  logic [N_LED-1:0] pat;
  logic [N_LED-1:0] pat_n;
  logic             phase;
  logic             phase_n;
  logic [BW-1:0]    bcnt;
  logic [BW-1:0]    bcnt_n;

  logic             restart;
  logic             tick;

  logic [N_LED-1:0] lit;
  logic             l_on;
  logic             r_on;
  logic [2:0]       rgb1_d;
  logic [2:0]       rgb2_d;

  assign raw = '{l: en_l, r: en_r,
                 hz: hazard, brk: brake};

  // two-flop input synchroniser
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  assign target  = pick_state(s2);
  assign restart = (target != state);

  step_tick #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // state, pattern and blink registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat   <= '0;
      phase <= 1'b1;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      pat   <= pat_n;
      phase <= phase_n;
      bcnt  <= bcnt_n;
    end
  end

  // next state, entry reloads and per-step updates
  always_comb begin
    state_n = target;
    pat_n   = pat;
    phase_n = phase;
    bcnt_n  = bcnt;
    if (restart) begin
      phase_n = 1'b1;
      bcnt_n  = '0;
      unique case (target)
        IDLE:   pat_n = '0;
        LEFT:   pat_n = L_INIT;
        RIGHT:  pat_n = R_INIT;
        HAZARD: pat_n = '1;
      endcase
    end else if (tick) begin
      unique case (state)
        IDLE:   pat_n = '0;
        LEFT:   pat_n = {pat[N_LED-2:0],
                         pat[N_LED-1]};
        RIGHT:  pat_n = {pat[0],
                         pat[N_LED-1:1]};
        HAZARD: pat_n = ~pat;
      endcase
      if (bcnt == BLAST) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n = bcnt + BW'(1);
      end
    end
  end

  // output decode from the upcoming state
  always_comb begin
    lit = pat_n;
    if (state_n == IDLE)
      lit = s2.brk ? '1 : '0;
    l_on = phase_n &&
           (state_n == LEFT || state_n == HAZARD);
    r_on = phase_n &&
           (state_n == RIGHT || state_n == HAZARD);
    rgb1_d = s2.brk ? RGB_RED : RGB_OFF;
    rgb2_d = s2.brk ? RGB_RED : RGB_OFF;
    if (l_on)
      rgb1_d = RGB_WHITE;
    if (r_on)
      rgb2_d = RGB_WHITE;
  end

  // registered, active-low outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      status_led_n <= '1;
      rgb_led_1_n  <= RGB_OFF;
      rgb_led_2_n  <= RGB_OFF;
    end else begin
      status_led_n <= ~lit;
      rgb_led_1_n  <= rgb1_d;
      rgb_led_2_n  <= rgb2_d;
    end
  end

endmodule

// File: tb/tb_car_light_seq.sv
// Scoreboard bench for car_light_seq.
// Expected outputs are queued per cycle.
module tb_car_light_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_l = 1'b0;
  logic       en_r = 1'b0;
  logic       hazard = 1'b0;
  logic       brake = 1'b0;
  logic [2:0] rgb_led_1_n;
  logic [2:0] rgb_led_2_n;
  logic [7:0] status_led_n;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    string       tag;
    logic [13:0] v;
  } exp_t;

  exp_t q[$];

  car_light_seq #(
    .N_LED       (8),
    .SEG_LEN     (4),
    .STEP_DIV    (4),
    .BLINK_STEPS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_l         (en_l),
    .en_r         (en_r),
    .hazard       (hazard),
    .brake        (brake),
    .rgb_led_1_n  (rgb_led_1_n),
    .rgb_led_2_n  (rgb_led_2_n),
    .status_led_n (status_led_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic push(
    input int          c,
    input string       tag,
    input logic [13:0] v
  );
    exp_t e;
    int   i;
    e.cyc = c;
    e.tag = tag;
    e.v   = v;
    i = 0;
    while (i < q.size() && q[i].cyc <= c)
      i++;
    q.insert(i, e);
  endtask

  task automatic exp_rng(
    input int         a,
    input int         b,
    input string      tag,
    input logic [7:0] st,
    input logic [2:0] l,
    input logic [2:0] r
  );
    for (int c = a; c <= b; c++)
      push(c, tag, {st, l, r});
  endtask

  task automatic drive_at(
    input int   t,
    input logic r,
    input logic l,
    input logic rr,
    input logic hz,
    input logic bk
  );
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
    rst    = r;
    en_l   = l;
    en_r   = rr;
    hazard = hz;
    brake  = bk;
  endtask

  // pop and compare everything due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc)
        check({e.tag, "_missed"},
              16'(e.cyc), 16'(cyc));
      else
        check(e.tag,
              {2'b0, status_led_n,
               rgb_led_1_n, rgb_led_2_n},
              {2'b0, e.v});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_rng(1, 3, "rst", 8'hFF, 3'h7, 3'h7);
    drive_at(3, 0, 0, 0, 0, 0);
    exp_rng(4, 28, "idle", 8'hFF, 3'h7, 3'h7);

    drive_at(26, 0, 1, 0, 0, 0);
    exp_rng(29, 32, "l0", 8'hF0, 3'h0, 3'h7);
    exp_rng(33, 36, "l1", 8'hE1, 3'h0, 3'h7);
    exp_rng(37, 40, "l2", 8'hC3, 3'h7, 3'h7);
    exp_rng(41, 44, "l3", 8'h87, 3'h7, 3'h7);
    exp_rng(45, 48, "l4", 8'h0F, 3'h0, 3'h7);

    drive_at(46, 0, 0, 1, 0, 0);
    exp_rng(49, 52, "r0", 8'h0F, 3'h7, 3'h0);
    exp_rng(53, 56, "r1", 8'h87, 3'h7, 3'h0);

    drive_at(55, 0, 1, 0, 0, 0);
    exp_rng(57, 57, "r2", 8'hC3, 3'h7, 3'h7);
    exp_rng(58, 61, "rl0", 8'hF0, 3'h0, 3'h7);
    exp_rng(62, 65, "rl1", 8'hE1, 3'h0, 3'h7);

    drive_at(64, 0, 1, 1, 0, 0);
    exp_rng(66, 66, "rl2", 8'hC3, 3'h7, 3'h7);
    exp_rng(67, 70, "hlr0", 8'h00, 3'h0, 3'h0);
    exp_rng(71, 74, "hlr1", 8'hFF, 3'h0, 3'h0);
    exp_rng(75, 78, "hlr2", 8'h00, 3'h7, 3'h7);
    exp_rng(79, 82, "hlr3", 8'hFF, 3'h7, 3'h7);
    exp_rng(83, 86, "hlr4", 8'h00, 3'h0, 3'h0);

    drive_at(84, 0, 0, 0, 0, 0);
    exp_rng(87, 92, "idle2", 8'hFF, 3'h7, 3'h7);

    drive_at(90, 0, 0, 0, 1, 0);
    exp_rng(93, 96, "hz0", 8'h00, 3'h0, 3'h0);
    exp_rng(97, 100, "hz1", 8'hFF, 3'h0, 3'h0);
    exp_rng(101, 104, "hz2", 8'h00, 3'h7, 3'h7);

    drive_at(104, 0, 0, 0, 0, 1);
    exp_rng(105, 106, "hz3", 8'hFF, 3'h7, 3'h7);
    exp_rng(107, 117, "brk_idle",
            8'h00, 3'h3, 3'h3);

    drive_at(115, 0, 1, 0, 0, 1);
    exp_rng(118, 121, "bl0", 8'hF0, 3'h0, 3'h3);
    exp_rng(122, 125, "bl1", 8'hE1, 3'h0, 3'h3);

    drive_at(123, 0, 1, 0, 0, 0);
    exp_rng(126, 129, "bl2", 8'hC3, 3'h7, 3'h7);
    exp_rng(130, 131, "bl3", 8'h87, 3'h7, 3'h7);

    drive_at(131, 1, 1, 0, 0, 0);
    exp_rng(132, 134, "mid_rst",
            8'hFF, 3'h7, 3'h7);
    drive_at(132, 0, 1, 0, 0, 0);
    exp_rng(135, 138, "rs0", 8'hF0, 3'h0, 3'h7);
    exp_rng(139, 142, "rs1", 8'hE1, 3'h0, 3'h7);

    drive_at(146, 0, 0, 0, 0, 0);
    check("drain", 16'(q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
